multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Parametrised multicycle CPU sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
//  emitting one-hot stage enables plus datapath controls decoded from the instruction select word.
//  Extends the fixed 5-state sequencer with a memory req/ack handshake with timeout, a halt/resume
//  handshake at the instruction boundary, a latched select word and a retired-instruction counter.
//  Sits between the decoder (supplies sel) and the PC/regfile/ALU/data-memory enables.
// PARAMETERS
//  SEL_W        7    width of sel; fields below are fixed LSB positions, upper bits ignored
//  WB_SEL_W     2    width of wb_ctrl field (sel[WB_SEL_W:1])
//  MEM_TIMEOUT  16   max cycles in MEM waiting for mem_ack before error (>=1)
//  CNT_W        32   width of retired-instruction counter
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset, asynchronous, active-high
//  sel        in   SEL_W     select: [0]=continue past EX, [WB_SEL_W:1]=wb src, [3]=mem access,
//                            [4]=store(1)/load(0), [5]=imm operand, [6]=jump
//  halt_req   in   1         request stop at next instruction boundary
//  mem_ack    in   1         data memory completes access (valid only while mem_req=1)
//  err_clr    in   1         leave ERROR state
//  pc_en,id_en,ex_en,mem_en,wb_en  out 1 each  one-hot stage enables
//  jump_en    out  1         = sel[6], captured in FETCH
//  imm_en     out  1         = sel_q[5]
//  expc_en    out  1         = (sel_q[2:1]==2'b01)
//  l_or_s     out  1         = sel_q[4]
//  wb_ctrl    out  WB_SEL_W  = sel_q[WB_SEL_W:1]
//  mem_req    out  1         high every cycle in MEM until ack/timeout
//  halted     out  1         high in HALT
//  err        out  1         high in ERROR
//  retired    out  CNT_W     count of completed instructions
// BEHAVIOUR
//  - Reset: state=FETCH, all outputs 0, sel_q=0, retired=0, wait counter=0. Mid-operation reset
//    abandons the instruction; no counter update.
//  - State encodings FETCH,DECODE,EXEC,MEM,WB,HALT,ERROR; stage enables are a decode of the state
//    register: exactly one high in FETCH..WB, all low in HALT/ERROR. mem_en==mem_req.
//  - FETCH: pc_en; jump_en<=sel[6]. If halt_req sampled high here -> HALT (no fetch), else DECODE.
//  - DECODE: id_en; sel_q<=sel at end of cycle; later stages use sel_q only (sel may change).
//  - EXEC: ex_en. next = !sel_q[0] ? FETCH(retire) : sel_q[3] ? MEM : WB.
//  - MEM: mem_req=1, wait counter increments each cycle. mem_ack=1 -> store: FETCH(retire);
//    load: WB. Counter reaching MEM_TIMEOUT with no ack -> ERROR (not retired). Ack on the
//    timeout cycle wins. Counter cleared on MEM entry.
//  - WB: wb_en for exactly 1 cycle -> FETCH(retire).
//  - Latency: 3 cycles (no-WB), 4 (ALU+WB), 4+n store / 5+n load, n = extra ack wait cycles (0 if
//    ack on first MEM cycle).
//  - HALT: halted=1; leave to FETCH the cycle after halt_req deasserts. halt_req never interrupts
//    an instruction in flight.
//  - ERROR: err=1, sticky until err_clr -> FETCH. err_clr ignored elsewhere. rst also clears.
//  - retired increments by 1 on each retire transition; wraps modulo 2^CNT_W.
//  - Control outputs (jump_en..wb_ctrl) are registered and hold between updates; no latches.
// STRUCTURE
//  - Package mcc_pkg: state enum, sel field index constants (SEL_CONT,SEL_MEM,SEL_ST,SEL_IMM,SEL_JMP).
//  - One sub-module mcc_wait_timer (loadable up-counter with terminal flag) for MEM timeout;
//    FSM, output registers and retired counter in top.
// TESTING
//  1 ALU op no WB: sel=7'b0000000 -> pc_en,id_en,ex_en on 3 consecutive cycles, retired 0->1.
//  2 ALU op with WB: sel=7'b0100011 -> imm_en=1, expc_en=1, wb_ctrl=2'b01, wb_en in cycle 4.
//  3 Load, ack after 2 wait cycles: sel=7'b0001001 -> mem_req 3 cycles, then wb_en, retired+1;
//    store sel=7'b0011001, ack first cycle -> no wb_en, back to FETCH.
//  4 MEM_TIMEOUT=4, ack never -> err=1 after 4 MEM cycles, retired unchanged; err_clr -> FETCH.
//  5 halt_req raised in EXEC -> instruction completes, HALT entered from FETCH with pc_en low;
//    deassert -> pc_en next cycle. sel changed after DECODE does not affect wb_ctrl.
//  6 rst asserted during MEM -> all outputs 0 immediately; CNT_W=4 wrap 15->0 on retire.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared types and select-word field positions for the multicycle sequencer.
package mcc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int SEL_CONT = 0;
    localparam int SEL_WB   = 1;
    localparam int SEL_MEM  = 3;
    localparam int SEL_ST   = 4;
    localparam int SEL_IMM  = 5;
    localparam int SEL_JMP  = 6;

endpackage

// File: rtl/mcc_wait_timer.sv
// Loadable up-counter bounding the time spent waiting for a memory acknowledge.
module mcc_wait_timer #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Flags the last permitted wait cycle so the FSM can leave on that same edge.
    assign done = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout, halt and retire count.
module multicycle_ctrl
    import mcc_pkg::*;
#(
    parameter int SEL_W       = 7,
    parameter int WB_SEL_W    = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel,
    input  logic                halt_req,
    input  logic                mem_ack,
    input  logic                err_clr,
    output logic                pc_en,
    output logic                id_en,
    output logic                ex_en,
    output logic                mem_en,
    output logic                wb_en,
    output logic                jump_en,
    output logic                imm_en,
    output logic                expc_en,
    output logic                l_or_s,
    output logic [WB_SEL_W-1:0] wb_ctrl,
    output logic                mem_req,
    output logic                halted,
    output logic                err,
    output logic [CNT_W-1:0]    retired
);

    state_t             state;
    state_t             state_nxt;
    logic               retire;
    logic               tmo_done;
    logic               tmo_clr;
    logic [SEL_JMP-1:0] sel_q;

    mcc_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmo_clr),
        .en   (state == ST_MEM),
        .done (tmo_done)
    );

    assign tmo_clr = (state != ST_MEM) && (state_nxt == ST_MEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_FETCH:  state_nxt = halt_req ? ST_HALT : ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (!sel_q[SEL_CONT]) begin
                    state_nxt = ST_FETCH;
                    retire    = 1'b1;
                end else if (sel_q[SEL_MEM]) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            // An acknowledge arriving on the final wait cycle takes priority over the timeout.
            ST_MEM: begin
                if (mem_ack) begin
                    if (sel_q[SEL_ST]) begin
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (tmo_done) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            ST_HALT:  state_nxt = halt_req ? ST_HALT : ST_FETCH;
            ST_ERROR: state_nxt = err_clr ? ST_FETCH : ST_ERROR;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_en <= 1'b0;
            sel_q   <= '0;
            retired <= '0;
        end else begin
            if (state == ST_FETCH && !halt_req) begin
                jump_en <= sel[SEL_JMP];
            end
            if (state == ST_DECODE) begin
                sel_q <= sel[SEL_JMP-1:0];
            end
            if (retire) begin
                retired <= retired + 1'b1;
            end
        end
    end

    // Stage strobes are forced low while reset is held so nothing fires during reset.
    assign pc_en   = !rst && (state == ST_FETCH);
    assign id_en   = !rst && (state == ST_DECODE);
    assign ex_en   = !rst && (state == ST_EXEC);
    assign mem_req = !rst && (state == ST_MEM);
    assign mem_en  = mem_req;
    assign wb_en   = !rst && (state == ST_WB);
    assign halted  = !rst && (state == ST_HALT);
    assign err     = !rst && (state == ST_ERROR);

    assign imm_en  = sel_q[SEL_IMM];
    assign expc_en = (sel_q[2:1] == 2'b01);
    assign l_or_s  = sel_q[SEL_ST];
    assign wb_ctrl = sel_q[WB_SEL_W:SEL_WB];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instructions vs. a per-instruction model.
module tb_multicycle_ctrl;

    localparam int SEL_W = 7;
    localparam int WB_W  = 2;
    localparam int TMO   = 4;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SEL_W-1:0] sel = '0;
    logic             halt_req = 1'b0;
    logic             mem_ack = 1'b0;
    logic             err_clr = 1'b0;
    logic             pc_en, id_en, ex_en, mem_en, wb_en;
    logic             jump_en, imm_en, expc_en, l_or_s;
    logic [WB_W-1:0]  wb_ctrl;
    logic             mem_req, halted, err;
    logic [CW-1:0]    retired;

    logic [4:0]       stg;
    logic [CW-1:0]    exp_ret = '0;
    int               total = 0;
    int               bad = 0;

    assign stg = {pc_en, id_en, ex_en, mem_en, wb_en};

    multicycle_ctrl #(
        .SEL_W       (SEL_W),
        .WB_SEL_W    (WB_W),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .halt_req (halt_req),
        .mem_ack  (mem_ack),
        .err_clr  (err_clr),
        .pc_en    (pc_en),
        .id_en    (id_en),
        .ex_en    (ex_en),
        .mem_en   (mem_en),
        .wb_en    (wb_en),
        .jump_en  (jump_en),
        .imm_en   (imm_en),
        .expc_en  (expc_en),
        .l_or_s   (l_or_s),
        .wb_ctrl  (wb_ctrl),
        .mem_req  (mem_req),
        .halted   (halted),
        .err      (err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] s);
        chk({tag, "_jump"}, 32'(jump_en), 32'(s[6]));
        chk({tag, "_imm"}, 32'(imm_en), 32'(s[5]));
        chk({tag, "_expc"}, 32'(expc_en), 32'(s[2:1] == 2'b01));
        chk({tag, "_lors"}, 32'(l_or_s), 32'(s[4]));
        chk({tag, "_wbctrl"}, 32'(wb_ctrl), 32'(s[2:1]));
    endtask

    // Runs one instruction from FETCH; ack_wait = MEM cycles before ack (>= TMO means never).
    task automatic do_instr(input logic [6:0] s, input int ack_wait, input bit halt_exec);
        bit timed_out;
        bit acked;
        bit needs_wb;
        timed_out = 1'b0;
        acked     = 1'b0;
        chk("fetch_stage", 32'(stg), 32'b10000);
        sel      = s;
        halt_req = 1'b0;
        err_clr  = 1'($urandom);
        @(negedge clk);
        chk("decode_stage", 32'(stg), 32'b01000);
        chk("decode_jump", 32'(jump_en), 32'(s[6]));
        err_clr  = 1'($urandom);
        @(negedge clk);
        chk("exec_stage", 32'(stg), 32'b00100);
        chk_ctrl("exec", s);
        sel      = 7'($urandom);
        err_clr  = 1'b0;
        halt_req = halt_exec;
        @(negedge clk);
        needs_wb = s[0] && !(s[3] && s[4]);
        if (s[0] && s[3]) begin
            for (int i = 0; i < TMO && !acked; i++) begin
                chk("mem_stage", 32'(stg), 32'b00010);
                chk("mem_req", 32'(mem_req), 32'd1);
                mem_ack = (i == ack_wait);
                @(negedge clk);
                acked   = mem_ack;
                mem_ack = 1'b0;
            end
            timed_out = !acked;
        end
        if (timed_out) begin
            chk("err_set", 32'(err), 32'd1);
            chk("err_stage", 32'(stg), 32'b00000);
            chk("err_ret", 32'(retired), 32'(exp_ret));
            @(negedge clk);
            chk("err_sticky", 32'(err), 32'd1);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("err_clr_fetch", 32'(stg), 32'b10000);
            chk("err_clr_err", 32'(err), 32'd0);
        end else begin
            if (needs_wb) begin
                chk("wb_stage", 32'(stg), 32'b00001);
                @(negedge clk);
            end
            exp_ret = exp_ret + 1'b1;
            chk("retired", 32'(retired), 32'(exp_ret));
            chk("back_fetch", 32'(stg), 32'b10000);
            chk_ctrl("hold", s);
        end
    endtask

    initial begin
        #1;
        chk("rst_stage", 32'(stg), 32'b00000);
        chk("rst_ret", 32'(retired), 32'd0);
        chk("rst_flags", 32'({halted, err, mem_req, jump_en, imm_en, expc_en, l_or_s, wb_ctrl}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        do_instr(7'b0000000, 0, 1'b0);
        do_instr(7'b0100011, 0, 1'b0);
        do_instr(7'b0001001, 2, 1'b0);
        do_instr(7'b0011001, 0, 1'b0);
        do_instr(7'b1001001, 3, 1'b0);
        do_instr(7'b0011001, 9, 1'b0);

        // Halt requested mid-instruction: the instruction retires first.
        do_instr(7'b0000011, 0, 1'b1);
        @(negedge clk);
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_stage", 32'(stg), 32'b00000);
        sel = 7'b1111111;
        @(negedge clk);
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_wbctrl", 32'(wb_ctrl), 32'b01);
        halt_req = 1'b0;
        @(negedge clk);
        chk("resume_pc", 32'(pc_en), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);

        for (int k = 0; k < 40; k++) begin
            do_instr(7'($urandom), int'($urandom_range(0, 5)), 1'b0);
        end

        // Reset mid-MEM abandons the instruction.
        sel = 7'b0001001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stage", 32'(stg), 32'b00000);
        chk("mid_rst_ret", 32'(retired), 32'd0);
        chk("mid_rst_flags", 32'({halted, err, mem_req, jump_en, imm_en, expc_en, l_or_s, wb_ctrl}), 32'd0);
        exp_ret = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) begin
            do_instr(7'b0000000, 0, 1'b0);
        end
        chk("wrap_zero", 32'(retired), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
